uart_rx_8n1: RTL and testbench

- 8N1 UART receive-only block, the receive partner of the transmit-only 8N1 UART.
- Synchronises the asynchronous rx pin and detects a start bit.
- Samples each bit at mid-bit using a clock divider, then presents the byte with a one-cycle strobe.
- Sits between the board rx pin and the consuming logic, for example a command parser or loopback back to the transmitter.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_8n1.sv | 125 ++++++++++++
 tb/tb_uart_rx_8n1.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divider and the
// receiver state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for a single asynchronous input. Both flops reset to
// RESET_VAL so an idle-high line does not look like an edge after reset.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage shift;
            // blocking ones would collapse both flops into one.
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronises rx, validates the start bit at half a bit,
// samples data and stop bits at mid-bit and strobes the byte or an error.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] rxbyte,
    output logic                      rxdone,
    output logic                      rxerror,
    output logic                      busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;

    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  DATA_LAST = 4'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx_8n1: CLKS_PER_BIT must be in 4..65535");
    end

    uart_rx_state_e r_state;
    uart_rx_state_e w_state_next;

    logic                      w_rx_s;
    logic                      w_sample;
    logic                      w_clk_clr;
    logic [15:0]               r_clk_cnt;
    logic [3:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_rxbyte;
    logic                      r_rxdone;
    logic                      r_rxerror;
    logic                      w_busy;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    // Mid-bit sample point: half a bit into START, a whole bit thereafter.
    always_comb begin
        w_sample = 1'b0;
        unique case (r_state)
            ST_START:         w_sample = (r_clk_cnt == HALF_LAST);
            ST_DATA, ST_STOP: w_sample = (r_clk_cnt == BIT_LAST);
            default:          w_sample = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: defaulting the next state first means every path assigns it,
        // so no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (!w_rx_s) w_state_next = ST_START;
            ST_START:     if (w_sample) w_state_next = w_rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_sample && r_bit_cnt == DATA_LAST) w_state_next = ST_STOP;
            ST_STOP:      if (w_sample) w_state_next = w_rx_s ? ST_IDLE : ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (w_rx_s) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    // Clock counter restarts on every state entry and every sample taken.
    assign w_clk_clr = w_sample || (w_state_next != r_state)
                    || (r_state == ST_IDLE) || (r_state == ST_WAIT_HIGH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rxbyte  <= '0;
            r_rxdone  <= 1'b0;
            r_rxerror <= 1'b0;
        end else begin
            r_rxdone  <= 1'b0;
            r_rxerror <= 1'b0;

            if (w_clk_clr) r_clk_cnt <= '0;
            else           r_clk_cnt <= r_clk_cnt + 16'd1;

            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == ST_DATA && w_sample) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            end

            if (r_state == ST_STOP && w_sample) begin
                if (w_rx_s) begin
                    r_rxbyte <= r_shift;
                    r_rxdone <= 1'b1;
                end else begin
                    r_rxerror <= 1'b1;
                end
            end
        end
    end

    assign rxbyte  = r_rxbyte;
    assign rxdone  = r_rxdone;
    assign rxerror = r_rxerror;
    assign busy    = w_busy;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: one instance at 16 clocks/bit for frame,
// glitch, framing, back-to-back and reset cases; one at 4 clocks/bit with jitter.
module tb_uart_rx_8n1;

    localparam int C16 = 16;
    localparam int H16 = C16 / 2;
    localparam int C4  = 4;
    // Pin edge to rxdone at the next falling clock edge: one edge into the
    // first sync flop, one to rx_s, one for IDLE to react, then H + 9 bits.
    localparam int DONE_LAT16 = 3 + H16 + 9 * C16;   // 155
    localparam int BUSY_LAT   = 3;
    localparam int BUSY_LEN16 = H16 + 9 * C16;       // 152

    logic       clk = 1'b0;
    logic       rst;
    logic       rx16, rx4;
    logic [7:0] byte16, byte4;
    logic       done16, err16, busy16;
    logic       done4, err4, busy4;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    int         done_cyc16[$];
    logic [7:0] done_byte16[$];
    int         err_n16 = 0;
    int         busy_n16 = 0;
    int         busy_rise16 = -1;
    logic       busy_prev16 = 1'b0;
    int         done_n4 = 0;
    int         err_n4 = 0;
    int         both_n = 0;
    int         t_fall16 = 0;

    uart_rx_8n1 #(.CLKS_PER_BIT(C16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx16),
        .rxbyte  (byte16),
        .rxdone  (done16),
        .rxerror (err16),
        .busy    (busy16)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(C4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx4),
        .rxbyte  (byte4),
        .rxdone  (done4),
        .rxerror (err4),
        .busy    (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done16) begin
            done_cyc16.push_back(cyc);
            done_byte16.push_back(byte16);
        end
        if (err16) err_n16++;
        if (busy16) busy_n16++;
        if (busy16 && !busy_prev16) busy_rise16 = cyc;
        busy_prev16 = busy16;
        if (done4) done_n4++;
        if (err4) err_n4++;
        if ((done16 && err16) || (done4 && err4)) both_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame on rx16 starting at a falling clock edge; the stop
    // level is held for stop_len cycles and left on the line afterwards.
    task automatic send16(input logic [7:0] data, input logic stop, input int stop_len);
        rx16     = 1'b0;
        t_fall16 = cyc;
        repeat (C16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx16 = data[i];
            repeat (C16) @(negedge clk);
        end
        rx16 = stop;
        repeat (stop_len) @(negedge clk);
    endtask

    // Drives one frame on rx4 with every bit edge moved by -1, 0 or +1 cycles.
    task automatic send4_jitter(input logic [7:0] data, input int seed);
        int         t [11];
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        t[0]  = 0;
        for (int j = 1; j < 10; j++) t[j] = C4 * j + ((j * seed) % 3) - 1;
        t[10] = 12 * C4;
        for (int j = 0; j < 10; j++) begin
            rx4 = bits[j];
            repeat (t[j+1] - t[j]) @(negedge clk);
        end
    endtask

    int nd, ne, nb, t0;

    initial begin
        rst  = 1'b1;
        rx16 = 1'b1;
        rx4  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_rxbyte",  32'(byte16), 32'h00);
        check("rst_rxdone",  32'(done16), 32'h0);
        check("rst_rxerror", 32'(err16),  32'h0);
        check("rst_busy",    32'(busy16), 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_busy", 32'(busy16), 32'h0);

        // Good frame 0xA5
        nd = done_cyc16.size(); ne = err_n16; nb = busy_n16;
        send16(8'hA5, 1'b1, C16);
        repeat (8) @(negedge clk);
        check("a5_count", 32'(done_cyc16.size() - nd), 32'd1);
        if (done_cyc16.size() > nd) begin
            check("a5_time", 32'(done_cyc16[nd]), 32'(t_fall16 + DONE_LAT16));
            check("a5_byte", 32'(done_byte16[nd]), 32'hA5);
        end
        check("a5_rxbyte",    32'(byte16), 32'hA5);
        check("a5_err",       32'(err_n16 - ne), 32'd0);
        check("a5_busy_rise", 32'(busy_rise16), 32'(t_fall16 + BUSY_LAT));
        check("a5_busy_len",  32'(busy_n16 - nb), 32'(BUSY_LEN16));

        // Glitch: rx low for 3 cycles
        nd = done_cyc16.size(); ne = err_n16; nb = busy_n16;
        t0 = cyc;
        rx16 = 1'b0;
        repeat (3) @(negedge clk);
        rx16 = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_done",      32'(done_cyc16.size() - nd), 32'd0);
        check("glitch_err",       32'(err_n16 - ne), 32'd0);
        check("glitch_busy_rise", 32'(busy_rise16), 32'(t0 + BUSY_LAT));
        check("glitch_busy_len",  32'(busy_n16 - nb), 32'(H16));

        // Framing error: 0x3C with stop held low for 40 cycles
        nd = done_cyc16.size(); ne = err_n16;
        send16(8'h3C, 1'b0, 40);
        check("ferr_err",       32'(err_n16 - ne), 32'd1);
        check("ferr_done",      32'(done_cyc16.size() - nd), 32'd0);
        check("ferr_rxbyte",    32'(byte16), 32'hA5);
        check("ferr_wait_busy", 32'(busy16), 32'h1);
        rx16 = 1'b1;
        repeat (6) @(negedge clk);
        check("ferr_release_busy", 32'(busy16), 32'h0);
        send16(8'h55, 1'b1, C16);
        repeat (8) @(negedge clk);
        check("after_ferr_count",  32'(done_cyc16.size() - nd), 32'd1);
        check("after_ferr_rxbyte", 32'(byte16), 32'h55);
        check("after_ferr_err",    32'(err_n16 - ne), 32'd1);

        // Back-to-back 0x00 then 0xFF
        nd = done_cyc16.size(); ne = err_n16;
        send16(8'h00, 1'b1, C16);
        send16(8'hFF, 1'b1, C16);
        repeat (8) @(negedge clk);
        check("b2b_count", 32'(done_cyc16.size() - nd), 32'd2);
        if (done_cyc16.size() >= nd + 2) begin
            check("b2b_byte0", 32'(done_byte16[nd]),   32'h00);
            check("b2b_byte1", 32'(done_byte16[nd+1]), 32'hFF);
            check("b2b_gap",   32'(done_cyc16[nd+1] - done_cyc16[nd]), 32'd160);
        end
        check("b2b_err", 32'(err_n16 - ne), 32'd0);

        // Reset for one cycle in the middle of data bit 4 of 0xF0
        nd = done_cyc16.size(); ne = err_n16;
        fork
            send16(8'hF0, 1'b1, C16);
            begin
                repeat (88) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("midrst_rxbyte",  32'(byte16), 32'h00);
                check("midrst_rxdone",  32'(done16), 32'h0);
                check("midrst_rxerror", 32'(err16),  32'h0);
                check("midrst_busy",    32'(busy16), 32'h0);
            end
        join
        repeat (40) @(negedge clk);
        check("midrst_no_done", 32'(done_cyc16.size() - nd), 32'd0);
        check("midrst_err_le1", 32'((err_n16 - ne) <= 1), 32'd1);
        send16(8'h81, 1'b1, C16);
        repeat (8) @(negedge clk);
        check("after_rst_count",  32'(done_cyc16.size() - nd), 32'd1);
        check("after_rst_rxbyte", 32'(byte16), 32'h81);

        // Four clocks per bit with jittered edges
        send4_jitter(8'h5A, 1);
        repeat (4) @(negedge clk);
        check("jit_5a_count", 32'(done_n4), 32'd1);
        check("jit_5a_byte",  32'(byte4), 32'h5A);
        send4_jitter(8'hC3, 2);
        repeat (4) @(negedge clk);
        check("jit_c3_count", 32'(done_n4), 32'd2);
        check("jit_c3_byte",  32'(byte4), 32'hC3);
        check("jit_err",      32'(err_n4), 32'd0);

        check("pulse_exclusive", 32'(both_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
